// File: rtl/systolic_drain.sv
// Output-side collector for the systolic shift array: re-aligns skewed lanes
// into whole rows and queues them in a small FIFO behind a valid/ready port.
module systolic_drain #(
    parameter int LANES = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES-1:0]         in_bits,
    output logic [LANES-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [LANES-2:0] vpipe_reg;
    logic [LANES-1:0] row_bits;
    logic             row_valid;

    // Valid travels alongside lane 0, so it needs the same LANES-1 stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_reg <= '0;
        end else begin
            vpipe_reg[0] <= in_valid;
            for (int i = 1; i < LANES - 1; i++) begin
                vpipe_reg[i] <= vpipe_reg[i-1];
            end
        end
    end

    assign row_valid = vpipe_reg[LANES-2];

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            localparam int D = LANES - 1 - gi;
            logic [D-1:0] dly_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_reg <= '0;
                end else begin
                    dly_reg[0] <= in_bits[gi];
                    for (int k = 1; k < D; k++) begin
                        dly_reg[k] <= dly_reg[k-1];
                    end
                end
            end

            assign row_bits[gi] = dly_reg[D-1];
        end
    endgenerate

    // The last lane arrives exactly when the row is complete.
    assign row_bits[LANES-1] = in_bits[LANES-1];

    logic [LANES-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      level_reg, level_next;
    logic             ovf_reg, ovf_next;
    logic             full, pop, push, drop;

    assign out_valid = (level_reg != '0);
    assign full      = (level_reg == FULL_LEVEL);
    assign pop       = out_valid && out_ready;
    assign push      = row_valid && (!full || pop);
    assign drop      = row_valid && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        ovf_next    = ovf_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push && !pop) begin
            level_next = level_reg + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_next = level_reg - (AW + 1)'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= row_bits;
        end
    end

    // Gate the head so an empty FIFO (including straight after reset) reads as zero.
    assign out_data = out_valid ? mem[rd_ptr_reg] : '0;
    assign level    = level_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: skewed row injection, FIFO fill/drain,
// overflow set/clear, simultaneous push/pop when full, async reset mid-stream.
module tb_systolic_drain;

    localparam int LANES = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_bits;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr;

    systolic_drain #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] row;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] hist_row [8];
    logic       hist_v   [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] row, input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] ed, input logic [2:0] el, input logic eo);
        vec_t t;
        t.v = v; t.row = row; t.rdy = rdy; t.clr = clr;
        t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
        tbl.push_back(t);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 8; i++) begin
            hist_row[i] = 8'h00;
            hist_v[i]   = 1'b0;
        end
    endtask

    // Called at a falling edge: lane j carries the row launched j steps ago.
    task automatic step(input logic v, input logic [7:0] row, input logic rdy, input logic clr);
        for (int i = 7; i > 0; i--) begin
            hist_row[i] = hist_row[i-1];
            hist_v[i]   = hist_v[i-1];
        end
        hist_row[0] = row;
        hist_v[0]   = v;
        for (int j = 0; j < 8; j++) begin
            in_bits[j] = hist_v[j] ? hist_row[j][j] : 1'($urandom_range(0, 1));
        end
        in_valid  = v;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bits = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        clear_hist();
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("idle%0d_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("idle%0d_level", c), 32'(level), 32'd0);
            chk($sformatf("idle%0d_ovf", c), 32'(overflow), 32'd0);
        end

        // Single row: visible after the eighth step for exactly one cycle.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int c = 1; c < 7; c++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("single_wait%0d_valid", c), 32'(out_valid), 32'd0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_level", 32'(level), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_gone_valid", 32'(out_valid), 32'd0);
        chk("single_gone_level", 32'(level), 32'd0);

        // Back-to-back rows, stall, then drain in order.
        add(1, 8'h01, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h80, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'hFF, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h3C, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  1, 8'h01, 1, 0);
        add(0, 8'h00, 0, 0,  1, 8'h01, 2, 0);
        add(0, 8'h00, 0, 0,  1, 8'h01, 3, 0);
        add(0, 8'h00, 0, 0,  1, 8'h01, 4, 0);
        add(0, 8'h00, 1, 0,  1, 8'h80, 3, 0);
        add(0, 8'h00, 1, 0,  1, 8'hFF, 2, 0);
        add(0, 8'h00, 1, 0,  1, 8'h3C, 1, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

        // Fifth row into a full FIFO is dropped; clear loses to a same-cycle drop.
        add(1, 8'h11, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h22, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h33, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h44, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h55, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 2, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 3, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 4, 0);
        add(0, 8'h00, 0, 1,  1, 8'h11, 4, 1);
        add(0, 8'h00, 0, 1,  1, 8'h11, 4, 0);
        add(0, 8'h00, 1, 0,  1, 8'h22, 3, 0);
        add(0, 8'h00, 1, 0,  1, 8'h33, 2, 0);
        add(0, 8'h00, 1, 0,  1, 8'h44, 1, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

        // Full FIFO popped on the cycle the fifth row completes: no drop.
        add(1, 8'h11, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h22, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h33, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h44, 0, 0,  0, 8'h00, 0, 0);
        add(1, 8'h55, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 2, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 3, 0);
        add(0, 8'h00, 0, 0,  1, 8'h11, 4, 0);
        add(0, 8'h00, 1, 0,  1, 8'h22, 4, 0);
        add(0, 8'h00, 1, 0,  1, 8'h33, 3, 0);
        add(0, 8'h00, 1, 0,  1, 8'h44, 2, 0);
        add(0, 8'h00, 1, 0,  1, 8'h55, 1, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].row, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].el));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
        end

        // Async reset with two rows queued and three still in the skew pipe.
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 1'b0, 1'b0);
        step(1'b1, 8'hC5, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd2);
        chk("pre_rst_data", 32'(out_data), 32'hC1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'h00);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b0;
        clear_hist();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2 * LANES; c++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("post_rst%0d_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("post_rst%0d_level", c), 32'(level), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side collector for the 8-lane systolic shift array.
- The array's lanes emerge skewed: lane j of a row exits j cycles after lane 0.
- This block de-skews the lanes back into whole rows and buffers them in a small FIFO.
- It presents rows to the pad-out logic with a valid/ready handshake and a sticky overflow flag.

Parameters:
- LANES, 8, number of array lanes = row width in bits (minimum 2).
- DEPTH, 4, FIFO depth in rows (power of two, minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  high on the cycle lane 0 of a row is presented.
- in_bits  input  LANES  array lane outputs; bit j belongs to the row whose in_valid was sampled j cycles earlier.
- out_data  output  LANES  head-of-FIFO row; bit j = lane j.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head row when out_valid && out_ready.
- level  output  $clog2(DEPTH)+1  rows currently held, 0..DEPTH.
- overflow  output  1  sticky: a completed row was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, deasserted synchronously upstream):
  - Delay lines, valid pipe, FIFO pointers, level and overflow are all cleared.
  - Outputs after reset: out_valid=0, level=0, overflow=0, out_data=0.
- De-skew:
  - Lane j passes through a register chain of depth LANES-1-j.
  - Lane LANES-1 uses no register; it feeds the row assembly combinationally.
  - in_valid passes through a LANES-1 stage valid pipe.
  - Row assembly: row_valid = valid pipe output; row_bits[j] = delayed lane j.
- Latency:
  - in_valid sampled at edge k → row written into the FIFO at edge k+LANES-1.
  - out_valid is high in the cycle following that edge (7 cycles of latency at LANES=8).
  - There is no bypass: an empty FIFO still goes through the write.
- Throughput:
  - One row per cycle.
  - Back-to-back in_valid is legal; rows may overlap in the skew window.
- FIFO:
  - push = row_valid && (level<DEPTH || pop); pop = out_valid && out_ready.
  - push && pop in the same cycle: level is unchanged, both pointers advance. This holds when full as well, so there is no drop.
  - Pointers wrap modulo DEPTH.
  - out_data is the registered or array-read value at the read pointer. It must be stable while out_valid && !out_ready.
  - pop while empty is ignored.
- Overflow:
  - row_valid && level==DEPTH && !pop → the row is discarded and overflow is set at that edge.
  - FIFO contents are untouched when a row is discarded.
  - ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins.
- Handshake rules:
  - out_valid never drops without a pop or reset.
  - out_ready may toggle freely.
- Reset mid-operation: rows in flight in the de-skew pipe are lost. No partial row may appear after reset.
- in_bits lanes whose row had no in_valid are don't-care and never reach the FIFO.

Test Plan:
- Reset then idle 20 cycles → out_valid=0, level=0, overflow=0 throughout.
- Single row 0xA5 fed skewed (in_valid at edge 0, bit j driven at edge j), out_ready=1 → out_valid rises after edge 7, out_data=0xA5 for exactly one cycle, level returns to 0.
- 4 back-to-back rows 0x01, 0x80, 0xFF, 0x3C with overlapping skew and out_ready=0 → level reaches 4. Then raise out_ready → rows drain in order, one per cycle, values exact.
- Fill to DEPTH with out_ready=0, then inject a fifth row 0x55 → overflow=1, level stays 4, drained data excludes 0x55. Then pulse ovf_clr → overflow=0.
- Full FIFO with out_ready=1 on the same cycle as the fifth row's completion → no drop, overflow stays 0, level stays 4, 0x55 is delivered last.
- Assert rst asynchronously mid-stream (3 rows in the pipe, 2 in the FIFO) → outputs clear immediately. After release, no stale row appears within 2*LANES cycles.
